vc_test_fixed_delay_source: RTL and testbench
=============================================

# vc_test_fixed_delay_source

Test-harness message source that feeds a design under test over a val/rdy interface, inserting a fixed number of idle cycles before every message. Messages come from an internal memory that the bench loads hierarchically before reset is released. It is the producer-side counterpart of the fixed-delay test sink: the pair brackets a DUT so that transfers are throttled on both ends with deterministic gaps.

## Interface

Parameters:
- p_msg_nbits, 1, width of each message in bits
- p_num_msgs, 1024, depth of the message memory `m[0:p_num_msgs-1]`

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- delay  input  32  idle cycles inserted before each message
- num_msgs  input  32  number of valid entries in `m`; values above p_num_msgs are clamped to p_num_msgs
- val  output  1  message valid
- rdy  input  1  downstream ready
- msg  output  p_msg_nbits  message payload, equal to `m[index]`
- done  output  1  high once all num_msgs messages have been accepted

## Operation

- **State:**
  - `index`: $clog2(p_num_msgs+1) bits, the next message to send.
  - `count`: 32 bits, remaining idle cycles.
  - Two-state FSM:
    - WAIT: `count` > 0.
    - SEND: `count` == 0 and not done.
- **Effective length:** `n_eff` = min(num_msgs, p_num_msgs). `num_msgs` must stay stable after reset is released.
- **Reset (any cycle `reset`=1):**
  - `index` <= 0.
  - `count` <= `delay`.
  - `val`=0 and `done`=0 during reset.
- **Outputs:**
  - `done` = !reset && (`index` == `n_eff`).
  - `val` = !reset && !done && (`count` == 0). Combinational from state, never from `rdy`.
- **WAIT:** `count` decrements by 1 each cycle. It never underflows.
- **SEND:** `val`=1 is held until the handshake; `msg` and `val` stay stable while `rdy`=0. On `val`&&`rdy` at the rising edge:
  - `index` increments by 1.
  - `count` <= `delay`, sampled at that edge.
  - With `delay`=0 the next message is valid the following cycle, so the block sustains full throughput.
- **Delay changes:** a new `delay` value takes effect only at the next load of `count` (reset or handshake). A change mid-countdown does not alter the countdown in progress.
- **Done:** after the last handshake, `done`=1 and `val`=0 permanently until the next reset. `rdy` is ignored.
- **n_eff = 0:** `done`=1 in the first cycle after reset. No message is ever sent, regardless of `delay`.
- **Reset mid-transfer:** `index` returns to 0 and the stream replays from `m[0]`. No partial state survives.

## Timing

- Reset is released at the edge ending cycle R. Cycle R+1 is the first non-reset cycle.
- The first `val`=1 occurs in cycle R+1+`delay`.
- Handshake in cycle T:
  - next `val`=1 in cycle T+1+`delay`;
  - there are exactly `delay` cycles with `val`=0 between consecutive transfers, provided `rdy` is high.
- Backpressure stall of k cycles: adds k cycles to that transfer only. It does not extend the next gap.
- `done` rises in the cycle after the final handshake.
- `msg` latency from state to output: 0 cycles (combinational read of `m[index]`).

## Configuration

- Macro: `VC_TEST_FIXED_DELAY_SOURCE_XMSG_EN`.
- **Defined:** `msg` is driven to all-X whenever `val`=0 (during reset, WAIT, and after done). Any DUT that consumes `msg` without `val` then propagates X, which the sink flags.
- **Undefined:** `msg` = `m[index]` while `index` < `n_eff`, and all-zero otherwise. It is never X.
- `val`, `done` and all timing are identical in both builds.

## Test plan

- **Back-to-back stream:** `m`={0x11,0x22,0x33}, `num_msgs`=3, `delay`=0, `rdy`=1.
  - Required: `val`=1 in cycles R+1..R+3 with `msg` 0x11, 0x22, 0x33.
  - `done`=1 from R+4; `val`=0 thereafter.
- **Fixed gaps:** same data, `delay`=2, `rdy`=1.
  - Required: transfers in cycles R+3, R+6, R+9 with exactly 2 idle cycles before each.
  - `done`=1 at R+10.
- **Backpressure:** `delay`=1; `rdy` held 0 for 3 cycles while `val`=1 on msg 0x22.
  - Required: `val` and `msg`=0x22 are stable across the stall; the transfer completes when `rdy`=1.
  - The next message is valid exactly 2 cycles after that transfer.
- **Mid-stream delay change:** `delay`=3; change to 0 during the first countdown.
  - Required: the first message still waits 3 cycles.
  - Subsequent messages are sent back-to-back.
- **Reset mid-stream and empty stream:**
  - Assert `reset` for 1 cycle after message 0x22 is accepted. Required: replay starts at 0x11 after `delay` cycles.
  - Set `num_msgs`=0. Required: `done`=1 at R+1 and `val` is never asserted.
- **Clamp and XMSG build:** `num_msgs`=2000 with `p_num_msgs`=4.
  - Required: exactly 4 transfers, then `done`.
  - With `VC_TEST_FIXED_DELAY_SOURCE_XMSG_EN` defined, `msg` is X on every `val`=0 cycle; without it, `msg`=0 after done.

Source files
------------

// File: rtl/vc_test_fixed_delay_source.sv
// vc_test_fixed_delay_source
// Test-harness message source: streams m[0..n_eff-1] over val/rdy, inserting
// a fixed number of idle cycles (delay) before every message. The message
// memory m is loaded hierarchically by the test bench before reset release.
//
// Build option: define VC_TEST_FIXED_DELAY_SOURCE_XMSG_EN to drive msg to
// all-X whenever val is low, so a consumer that ignores val propagates X.
// Without it, msg shows m[index] while messages remain and zero afterwards.

module vc_test_fixed_delay_source #(
  parameter int p_msg_nbits = 1,
  parameter int p_num_msgs  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            delay,
  input  logic [31:0]            num_msgs,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  localparam int c_idx_nbits  = $clog2(p_num_msgs + 1);
  localparam int c_addr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam logic [31:0] c_depth = 32'(p_num_msgs);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Message memory, written only by the bench through hierarchy.
  logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

  logic [c_idx_nbits-1:0]  index_q, index_d;
  logic [31:0]             count_q, count_d;
  state_t                  state_s;
  logic [31:0]             n_eff_s;
  logic [31:0]             index_ext_s;
  logic [c_addr_nbits-1:0] rd_addr_s;
  logic                    xfer_s;

  // Number of messages actually sent: num_msgs clamped to the memory depth.
  assign n_eff_s     = (num_msgs > c_depth) ? c_depth : num_msgs;
  assign index_ext_s = 32'(index_q);
  // Only consulted while index < n_eff <= p_num_msgs, so truncation is safe.
  assign rd_addr_s   = index_q[c_addr_nbits-1:0];

  // State decode, outputs and next-state; val never depends on rdy.
  always_comb begin
    state_s = ST_SEND;
    index_d = index_q;
    count_d = count_q;
    val     = 1'b0;
    done    = 1'b0;
    xfer_s  = 1'b0;

    if (count_q != 32'd0) begin
      state_s = ST_WAIT;
    end else begin
      state_s = ST_SEND;
    end

    done = !reset && (index_ext_s == n_eff_s);

    case (state_s)
      ST_WAIT: begin
        // count_q is nonzero here, so the decrement cannot underflow.
        count_d = count_q - 32'd1;
      end
      ST_SEND: begin
        val    = !reset && !done;
        xfer_s = val && rdy;
        if (xfer_s) begin
          index_d = index_q + c_idx_nbits'(1);
          count_d = delay;
        end else begin
          index_d = index_q;
          count_d = count_q;
        end
      end
      default: begin
        index_d = index_q;
        count_d = count_q;
      end
    endcase
  end

  // Payload read: combinational from index, masked according to build option.
  always_comb begin
    msg = {p_msg_nbits{1'b0}};
`ifdef VC_TEST_FIXED_DELAY_SOURCE_XMSG_EN
    if (val) begin
      msg = m[rd_addr_s];
    end else begin
      msg = {p_msg_nbits{1'bx}};
    end
`else
    if (index_ext_s < n_eff_s) begin
      msg = m[rd_addr_s];
    end else begin
      msg = {p_msg_nbits{1'b0}};
    end
`endif
  end

  // State registers; reset rewinds the stream and reloads the idle countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= {c_idx_nbits{1'b0}};
      count_q <= delay;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_vc_test_fixed_delay_source.sv
// Directed bench for vc_test_fixed_delay_source: back-to-back, fixed gaps,
// backpressure, mid-countdown delay change, reset mid-stream, empty stream
// and num_msgs clamping. Expected values are hand-computed per cycle.

module tb_vc_test_fixed_delay_source;

  logic        clk;
  logic        reset;
  logic [31:0] delay;
  logic [31:0] num_msgs;
  logic        val;
  logic        rdy;
  logic [7:0]  msg;
  logic        done;

  int n_checks;
  int n_fail;

  vc_test_fixed_delay_source #(
    .p_msg_nbits (8),
    .p_num_msgs  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .delay    (delay),
    .num_msgs (num_msgs),
    .val      (val),
    .rdy      (rdy),
    .msg      (msg),
    .done     (done)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample at negedge, move past next posedge.
  task automatic cyc(input string tag, input logic rst_in, input logic rdy_in,
                     input logic ev, input logic [7:0] em, input logic ed);
    logic [7:0] exp_msg;
    reset = rst_in;
    rdy   = rdy_in;
    @(negedge clk);
    exp_msg = em;
`ifdef VC_TEST_FIXED_DELAY_SOURCE_XMSG_EN
    if (!ev) exp_msg = 8'hxx;
`endif
    check_value({tag, "_val"},  {31'd0, val},  {31'd0, ev});
    check_value({tag, "_msg"},  {24'd0, msg},  {24'd0, exp_msg});
    check_value({tag, "_done"}, {31'd0, done}, {31'd0, ed});
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles (val/done must stay low); returns at start of cycle R+1.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_value({tag, "_rst_val"},  {31'd0, val},  32'd0);
      check_value({tag, "_rst_done"}, {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rdy      = 1'b0;
    delay    = 32'd0;
    num_msgs = 32'd3;
    dut.m[0] = 8'h11;
    dut.m[1] = 8'h22;
    dut.m[2] = 8'h33;
    dut.m[3] = 8'h44;

    // Back-to-back stream, delay 0.
    delay = 32'd0; num_msgs = 32'd3;
    apply_reset("b2b");
    cyc("b2b_r1", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("b2b_r2", 1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc("b2b_r3", 1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    cyc("b2b_r4", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc("b2b_r5", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Fixed gaps, delay 2: transfers at R+3, R+6, R+9.
    delay = 32'd2;
    apply_reset("gap");
    cyc("gap_r1",  1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("gap_r2",  1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("gap_r3",  1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("gap_r4",  1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
    cyc("gap_r5",  1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
    cyc("gap_r6",  1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc("gap_r7",  1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    cyc("gap_r8",  1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    cyc("gap_r9",  1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    cyc("gap_r10", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Backpressure, delay 1: 3-cycle stall on 0x22.
    delay = 32'd1;
    apply_reset("bp");
    cyc("bp_r1",  1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("bp_r2",  1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("bp_r3",  1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
    cyc("bp_r4",  1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    cyc("bp_r5",  1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    cyc("bp_r6",  1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
    cyc("bp_r7",  1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc("bp_r8",  1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    cyc("bp_r9",  1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    cyc("bp_r10", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Delay 3 loaded at reset, changed to 0 during the first countdown.
    delay = 32'd3;
    apply_reset("dchg");
    delay = 32'd0;
    cyc("dchg_r1", 1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("dchg_r2", 1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("dchg_r3", 1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("dchg_r4", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("dchg_r5", 1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc("dchg_r6", 1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    cyc("dchg_r7", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Reset for one cycle after 0x22 is accepted; stream replays from 0x11.
    delay = 32'd1;
    apply_reset("rmid");
    cyc("rmid_r1", 1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("rmid_r2", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("rmid_r3", 1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
    cyc("rmid_r4", 1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc("rmid_rst", 1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    cyc("rmid_p1", 1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    cyc("rmid_p2", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("rmid_p3", 1'b0, 1'b1, 1'b0, 8'h22, 1'b0);

    // Empty stream: done from R+1, val never asserted.
    delay = 32'd2; num_msgs = 32'd0;
    apply_reset("empty");
    for (int i = 1; i <= 4; i++) begin
      cyc($sformatf("empty_r%0d", i), 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    end

    // Clamp: num_msgs 2000 against a depth of 4.
    delay = 32'd0; num_msgs = 32'd2000;
    apply_reset("clamp");
    cyc("clamp_r1", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    cyc("clamp_r2", 1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    cyc("clamp_r3", 1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    cyc("clamp_r4", 1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
    cyc("clamp_r5", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    cyc("clamp_r6", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
